// File: rtl/smg_pkg.sv
// rtl/smg_pkg.sv - shared constants, state encoding and helpers for the seven-segment bus receiver
package smg_pkg;

  // Active-low segment codes with dp (bit 7) held high.
  localparam logic [7:0] N0 = 8'hC0;
  localparam logic [7:0] N1 = 8'hF9;
  localparam logic [7:0] N2 = 8'hA4;
  localparam logic [7:0] N3 = 8'hB0;
  localparam logic [7:0] N4 = 8'h99;
  localparam logic [7:0] N5 = 8'h92;
  localparam logic [7:0] N6 = 8'h82;
  localparam logic [7:0] N7 = 8'hF8;
  localparam logic [7:0] N8 = 8'h80;
  localparam logic [7:0] N9 = 8'h90;
  localparam logic [7:0] NA = 8'h88;
  localparam logic [7:0] NB = 8'h83;
  localparam logic [7:0] NC = 8'hC6;
  localparam logic [7:0] ND = 8'hA1;
  localparam logic [7:0] NE = 8'h86;
  localparam logic [7:0] NF = 8'h8E;

  localparam logic [1:0] CS_ONES = 2'b10;
  localparam logic [1:0] CS_TENS = 2'b01;
  localparam logic [1:0] CS_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } smg_state_e;

  function automatic logic [6:0] dec_value(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t7;
    logic [6:0] o7;
    t7 = {3'b000, tens};
    o7 = {3'b000, ones};
    return (t7 << 3) + (t7 << 1) + o7;
  endfunction

endpackage

// File: rtl/smg_seg_decode.sv
// rtl/smg_seg_decode.sv - combinational active-low segment pattern to hex nibble decoder
module smg_seg_decode
  import smg_pkg::*;
(
  input  logic [7:0] dx_i,
  output logic [3:0] nibble_o,
  output logic       hit_o
);

  logic [7:0] code;

  // The decimal point carries no digit information, so it is forced off.
  assign code = dx_i | 8'h80;

  always_comb begin
    nibble_o = 4'h0;
    hit_o    = 1'b1;
    case (code)
      N0: nibble_o = 4'h0;
      N1: nibble_o = 4'h1;
      N2: nibble_o = 4'h2;
      N3: nibble_o = 4'h3;
      N4: nibble_o = 4'h4;
      N5: nibble_o = 4'h5;
      N6: nibble_o = 4'h6;
      N7: nibble_o = 4'h7;
      N8: nibble_o = 4'h8;
      N9: nibble_o = 4'h9;
      NA: nibble_o = 4'hA;
      NB: nibble_o = 4'hB;
      NC: nibble_o = 4'hC;
      ND: nibble_o = 4'hD;
      NE: nibble_o = 4'hE;
      NF: nibble_o = 4'hF;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/smg_scan_decoder.sv
// rtl/smg_scan_decoder.sv - passive 2-digit multiplexed seven-segment bus receiver and frame assembler
module smg_scan_decoder
  import smg_pkg::*;
#(
  parameter logic [15:0] SETTLE  = 16'd1000,
  parameter logic [25:0] TIMEOUT = 26'd5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cs_in,
  input  logic [7:0] dx_in,
  output logic [7:0] hex_out,
  output logic [6:0] dec_out,
  output logic       dec_ok,
  output logic       frame_valid,
  output logic       frame_chg,
  output logic       seg_err,
  output logic       stale
);

  logic [1:0]  cs_m_q, cs_s_q;
  logic [7:0]  dx_m_q, dx_s_q;

  smg_state_e  state_q, state_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [1:0]  cs_cur_q, cs_cur_d;
  logic        capture;

  logic [3:0]  ones_q, ones_d, tens_q, tens_d;
  logic        got_one_q, got_one_d, got_ten_q, got_ten_d;
  logic        frame_pend_q, frame_pend_d;
  logic        seg_err_q, seg_err_d;
  logic [25:0] timeout_cnt_q, timeout_cnt_d;
  logic        stale_q, stale_d;

  logic [7:0]  hex_q;
  logic [6:0]  dec_q;
  logic        dec_ok_q, frame_valid_q, frame_chg_q;

  logic [3:0]  dec_nib;
  logic        dec_hit;
  logic [7:0]  new_hex;
  logic        new_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_m_q <= CS_NONE;
      cs_s_q <= CS_NONE;
      dx_m_q <= 8'hFF;
      dx_s_q <= 8'hFF;
    end else begin
      cs_m_q <= cs_in;
      cs_s_q <= cs_m_q;
      dx_m_q <= dx_in;
      dx_s_q <= dx_m_q;
    end
  end

  smg_seg_decode u_seg_decode (
    .dx_i     (dx_s_q),
    .nibble_o (dec_nib),
    .hit_o    (dec_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= 16'd0;
      cs_cur_q     <= CS_NONE;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      cs_cur_q     <= cs_cur_d;
    end
  end

  // One capture per dwell: only the SETTLE -> HELD transition samples dx.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    cs_cur_d     = cs_cur_q;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_s_q == CS_ONES || cs_s_q == CS_TENS) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = 16'd1;
          cs_cur_d     = cs_s_q;
        end
      end
      ST_SETTLE: begin
        if (cs_s_q != cs_cur_q) begin
          state_d = ST_IDLE;
        end else if (settle_cnt_q == SETTLE) begin
          capture = 1'b1;
          state_d = ST_HELD;
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end
      ST_HELD: begin
        if (cs_s_q != cs_cur_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ones_d        = ones_q;
    tens_d        = tens_q;
    got_one_d     = got_one_q;
    got_ten_d     = got_ten_q;
    seg_err_d     = seg_err_q;
    timeout_cnt_d = timeout_cnt_q;
    stale_d       = stale_q;
    frame_pend_d  = 1'b0;
    if (frame_pend_q) begin
      got_one_d = 1'b0;
      got_ten_d = 1'b0;
    end
    // A capture overrides the timeout path entirely, including its flag clearing.
    if (capture) begin
      timeout_cnt_d = 26'd0;
      stale_d       = 1'b0;
      if (dec_hit) begin
        if (cs_cur_q == CS_ONES) begin
          ones_d    = dec_nib;
          got_one_d = 1'b1;
        end else begin
          tens_d    = dec_nib;
          got_ten_d = 1'b1;
        end
        frame_pend_d = got_one_d & got_ten_d;
      end else begin
        seg_err_d = 1'b1;
        got_one_d = 1'b0;
        got_ten_d = 1'b0;
      end
    end else if (timeout_cnt_q != TIMEOUT) begin
      timeout_cnt_d = timeout_cnt_q + 26'd1;
      if (timeout_cnt_d == TIMEOUT) begin
        stale_d   = 1'b1;
        got_one_d = 1'b0;
        got_ten_d = 1'b0;
      end
    end
  end

  assign new_hex = {tens_q, ones_q};
  assign new_ok  = (tens_q <= 4'd9) && (ones_q <= 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q        <= 4'h0;
      tens_q        <= 4'h0;
      got_one_q     <= 1'b0;
      got_ten_q     <= 1'b0;
      frame_pend_q  <= 1'b0;
      seg_err_q     <= 1'b0;
      timeout_cnt_q <= 26'd0;
      stale_q       <= 1'b0;
      hex_q         <= 8'h00;
      dec_q         <= 7'd0;
      dec_ok_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_chg_q   <= 1'b0;
    end else begin
      ones_q        <= ones_d;
      tens_q        <= tens_d;
      got_one_q     <= got_one_d;
      got_ten_q     <= got_ten_d;
      frame_pend_q  <= frame_pend_d;
      seg_err_q     <= seg_err_d;
      timeout_cnt_q <= timeout_cnt_d;
      stale_q       <= stale_d;
      frame_valid_q <= frame_pend_q;
      frame_chg_q   <= frame_pend_q && (new_hex != hex_q);
      if (frame_pend_q) begin
        hex_q    <= new_hex;
        dec_ok_q <= new_ok;
        dec_q    <= new_ok ? dec_value(tens_q, ones_q) : 7'd0;
      end
    end
  end

  assign hex_out     = hex_q;
  assign dec_out     = dec_q;
  assign dec_ok      = dec_ok_q;
  assign frame_valid = frame_valid_q;
  assign frame_chg   = frame_chg_q;
  assign seg_err     = seg_err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_smg_scan_decoder.sv
// tb/tb_smg_scan_decoder.sv - scoreboard bench for the seven-segment bus receiver
module tb_smg_scan_decoder;

  localparam logic [15:0] SETTLE_P  = 16'd20;
  localparam logic [25:0] TIMEOUT_P = 26'd3000;
  localparam int DWELL = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cs_in = 2'b11;
  logic [7:0] dx_in = 8'hFF;
  logic [7:0] hex_out;
  logic [6:0] dec_out;
  logic       dec_ok, frame_valid, frame_chg, seg_err, stale;

  typedef struct {
    logic [7:0] hex;
    logic [6:0] dec;
    logic       ok;
    logic       chg;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  smg_scan_decoder #(.SETTLE(SETTLE_P), .TIMEOUT(TIMEOUT_P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_in       (cs_in),
    .dx_in       (dx_in),
    .hex_out     (hex_out),
    .dec_out     (dec_out),
    .dec_ok      (dec_ok),
    .frame_valid (frame_valid),
    .frame_chg   (frame_chg),
    .seg_err     (seg_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] hex, input logic [6:0] dec, input logic ok, input logic chg);
    exp_t e;
    e.hex = hex; e.dec = dec; e.ok = ok; e.chg = chg;
    exp_q.push_back(e);
  endtask

  task automatic dwell(input logic [1:0] c, input logic [7:0] d, input int n);
    cs_in = c;
    dx_in = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dwell(2'b11, 8'hFF, n);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    chk({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_hex"}, hex_out, 8'h00);
    chk({name, "_dec"}, dec_out, 7'd0);
    chk({name, "_ok"}, dec_ok, 1'b0);
    chk({name, "_fv"}, frame_valid, 1'b0);
    chk({name, "_chg"}, frame_chg, 1'b0);
    chk({name, "_segerr"}, seg_err, 1'b0);
    chk({name, "_stale"}, stale, 1'b0);
  endtask

  // Monitor: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_hex", {24'd0, hex_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_hex", hex_out, e.hex);
        chk("frame_dec", dec_out, e.dec);
        chk("frame_ok", dec_ok, e.ok);
        chk("frame_chg", frame_chg, e.chg);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("in_reset");
    rst_n = 1'b1;
    idle(5);
    chk_reset_state("after_reset");

    // Frame 25 from ones=5 then tens=2
    push(8'h25, 7'd25, 1'b1, 1'b1);
    dwell(2'b10, 8'h92, DWELL);
    dwell(2'b01, 8'hA4, DWELL);
    idle(10);
    drain("f25");

    // Same frame again, tens first, then BF
    push(8'h25, 7'd25, 1'b1, 1'b0);
    dwell(2'b01, 8'hA4, DWELL);
    dwell(2'b10, 8'h92, DWELL);
    idle(10);
    drain("f25_repeat");
    push(8'hBF, 7'd0, 1'b0, 1'b1);
    dwell(2'b10, 8'h8E, DWELL);
    dwell(2'b01, 8'h83, DWELL);
    idle(10);
    drain("fBF");

    // Short ones dwell must not capture; lone tens then must not complete a frame
    dwell(2'b10, 8'h92, int'(SETTLE_P) - 10);
    idle(10);
    dwell(2'b01, 8'hF9, DWELL);
    idle(40);
    push(8'h14, 7'd14, 1'b1, 1'b1);
    dwell(2'b10, 8'h99, DWELL);
    idle(10);
    drain("f14_glitch");
    chk("segerr_clean", seg_err, 1'b0);

    // Invalid pattern aborts the frame and sets the sticky error
    dwell(2'b01, 8'hF8, DWELL);
    dwell(2'b10, 8'hFF, DWELL);
    idle(10);
    chk("segerr_set", seg_err, 1'b1);
    dwell(2'b10, 8'h99, DWELL);
    idle(40);
    // dx=00 decodes as 8 because the dp bit is ignored
    push(8'h84, 7'd84, 1'b1, 1'b1);
    dwell(2'b01, 8'h00, DWELL);
    idle(10);
    drain("f84_after_abort");
    chk("segerr_sticky", seg_err, 1'b1);

    // Timeout after frame 25
    push(8'h25, 7'd25, 1'b1, 1'b1);
    dwell(2'b10, 8'h92, DWELL);
    dwell(2'b01, 8'hA4, DWELL);
    drain("f25_pre_timeout");
    idle(1000);
    chk("stale_early", stale, 1'b0);
    idle(int'(TIMEOUT_P) - 900);
    chk("stale_set", stale, 1'b1);
    chk("stale_hex_kept", hex_out, 8'h25);
    chk("stale_dec_kept", dec_out, 7'd25);
    dwell(2'b10, 8'h92, DWELL);
    chk("stale_cleared", stale, 1'b0);

    // Reset with only the ones digit captured
    @(posedge clk);
    #3 rst_n = 1'b0;
    #2;
    chk_reset_state("mid_frame_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    dwell(2'b01, 8'hA4, DWELL);
    idle(40);
    push(8'h29, 7'd29, 1'b1, 1'b1);
    dwell(2'b10, 8'h90, DWELL);
    idle(10);
    drain("f29_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
